// File: rtl/alu_issue_arb_pkg.sv
// alu_arb_pkg: shared types and constants for the two-requester ALU issue controller
package alu_arb_pkg;
   localparam int DATA_W = 64;
   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_XOR = 2'b11
   } alu_fn_t;
   localparam int CC_ZF = 2;
   localparam int CC_SF = 1;
   localparam int CC_OF = 0;
   localparam logic [2:0] CC_RESET = 3'b100;
   typedef struct packed {
      alu_fn_t           fn;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic              setcc;
      logic              id;
      logic              valid;
   } stage_t;
   function automatic logic [2:0] next_cc(alu_fn_t fn, logic [DATA_W-1:0] r, logic of);
      next_cc = '0;
      next_cc[CC_ZF] = r == '0;
      next_cc[CC_SF] = r[DATA_W-1];
      next_cc[CC_OF] = (fn == ALU_ADD || fn == ALU_SUB) ? of : 1'b0;
   endfunction
endpackage

// File: rtl/alu_issue_arb_if.sv
// alu_issue_arb_if: request, response, ALU and status signals of the ALU issue controller
interface alu_issue_arb_if;
   import alu_arb_pkg::*;
   logic              req0_valid;
   logic              req0_ready;
   logic [1:0]        req0_fn;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic              req0_setcc;
   logic              req1_valid;
   logic              req1_ready;
   logic [1:0]        req1_fn;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic              req1_setcc;
   logic              rsp0_valid;
   logic [DATA_W-1:0] rsp0_data;
   logic              rsp1_valid;
   logic [DATA_W-1:0] rsp1_data;
   logic [1:0]        alu_control;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_out;
   logic              alu_of;
   logic [2:0]        cc;
   logic              flush;
   logic              busy;
   modport master (
      output req0_valid, req0_fn, req0_a, req0_b, req0_setcc,
      output req1_valid, req1_fn, req1_a, req1_b, req1_setcc,
      output alu_out, alu_of, flush,
      input  req0_ready, req1_ready, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
      input  alu_control, alu_a, alu_b, cc, busy
   );
   modport slave (
      input  req0_valid, req0_fn, req0_a, req0_b, req0_setcc,
      input  req1_valid, req1_fn, req1_a, req1_b, req1_setcc,
      input  alu_out, alu_of, flush,
      output req0_ready, req1_ready, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
      output alu_control, alu_a, alu_b, cc, busy
   );
endinterface

// File: rtl/alu_issue_arb_arb_rr2.sv
// arb_rr2: 2-way grant logic; round-robin when ALU_ARB_RR_EN is defined, else fixed priority to req0
module arb_rr2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] valid,
   output logic [1:0] grant
);
`ifdef ALU_ARB_RR_EN
   logic ptr;
   // ptr=0 favours req0 under contention, ptr=1 favours req1
   always_comb begin
      grant[0] = en & valid[0] & (~valid[1] | ~ptr);
      grant[1] = en & valid[1] & (~valid[0] | ptr);
   end
   // a grant is always a handshake, so point away from whoever just won
   always_ff @(posedge clk)
      if (rst) ptr <= 1'b0;
      else if (|grant) ptr <= grant[0];
`else
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst;
   assign grant = {en & valid[1] & ~valid[0], en & valid[0]};
`endif
endmodule

// File: rtl/alu_issue_arb.sv
// alu_issue_arb: issues one op per cycle from two requesters to the shared ALU, returns results and keeps {ZF,SF,OF}
module alu_issue_arb import alu_arb_pkg::*; (
   input logic            clk,
   input logic            rst,
   alu_issue_arb_if.slave bus
);
   logic [1:0]        grant;
   stage_t            stage;
   logic              fire;
   logic              rsp0_v;
   logic              rsp1_v;
   logic [DATA_W-1:0] rsp0_d;
   logic [DATA_W-1:0] rsp1_d;
   logic [2:0]        cc_q;
   arb_rr2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .en    (~rst & ~bus.flush),
      .valid ({bus.req1_valid, bus.req0_valid}),
      .grant (grant)
   );
   assign fire = stage.valid & ~bus.flush;
   // load the granted op; when idle only valid drops so the ALU inputs keep their last values
   always_ff @(posedge clk)
      if (rst) stage <= '0;
      else if (|grant) stage <= '{
         fn:    alu_fn_t'(grant[1] ? bus.req1_fn : bus.req0_fn),
         a:     grant[1] ? bus.req1_a : bus.req0_a,
         b:     grant[1] ? bus.req1_b : bus.req0_b,
         setcc: grant[1] ? bus.req1_setcc : bus.req0_setcc,
         id:    grant[1],
         valid: 1'b1
      };
      else stage.valid <= 1'b0;
   // capture the ALU result for the owning requester and update CC unless the op is flushed
   always_ff @(posedge clk)
      if (rst) begin
         rsp0_v <= 1'b0;
         rsp1_v <= 1'b0;
         rsp0_d <= '0;
         rsp1_d <= '0;
         cc_q   <= CC_RESET;
      end else begin
         rsp0_v <= fire & ~stage.id;
         rsp1_v <= fire & stage.id;
         if (fire & ~stage.id) rsp0_d <= bus.alu_out;
         if (fire & stage.id) rsp1_d <= bus.alu_out;
         if (fire & stage.setcc) cc_q <= next_cc(stage.fn, bus.alu_out, bus.alu_of);
      end
   assign bus.req0_ready  = grant[0];
   assign bus.req1_ready  = grant[1];
   assign bus.rsp0_valid  = rsp0_v;
   assign bus.rsp1_valid  = rsp1_v;
   assign bus.rsp0_data   = rsp0_d;
   assign bus.rsp1_data   = rsp1_d;
   assign bus.alu_control = stage.fn;
   assign bus.alu_a       = stage.a;
   assign bus.alu_b       = stage.b;
   assign bus.cc          = cc_q;
   assign bus.busy        = stage.valid;
endmodule

// File: tb/tb_alu_issue_arb.sv
// tb_alu_issue_arb: directed table, corner sequences and randomized model check of alu_issue_arb
module tb_alu_issue_arb;
   import alu_arb_pkg::*;
`ifdef ALU_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   typedef struct {
      logic [1:0]  fn;
      logic [63:0] a;
      logic [63:0] b;
      logic        setcc;
   } op_t;
   typedef struct {
      int          id;
      op_t         op;
      logic [63:0] exp_d;
      logic [2:0]  exp_cc;
   } vec_t;
   logic clk = 1'b0;
   logic rst;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   alu_issue_arb_if bus();
   alu_issue_arb dut (.clk(clk), .rst(rst), .bus(bus));
   // external ALU; for logic ops it reports a deliberately meaningless overflow flag
   function automatic logic [64:0] env_alu(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
      logic [63:0] r;
      r = f == 2'd0 ? a + b : f == 2'd1 ? a - b : f == 2'd2 ? a & b : a ^ b;
      env_alu = {f[1] ? ~r[0] : (a[63] ^ r[63]) & ~(a[63] ^ b[63] ^ f[0]), r};
   endfunction
   assign {bus.alu_of, bus.alu_out} = env_alu(bus.alu_control, bus.alu_a, bus.alu_b);
   function automatic logic [63:0] ref_res(input op_t o);
      case (o.fn)
         2'd0:    ref_res = o.a + o.b;
         2'd1:    ref_res = o.a - o.b;
         2'd2:    ref_res = o.a & o.b;
         default: ref_res = o.a ^ o.b;
      endcase
   endfunction
   function automatic logic [2:0] ref_cc(input op_t o);
      logic [64:0] w;
      logic [63:0] r;
      r = ref_res(o);
      w = o.fn == 2'd0 ? {o.a[63], o.a} + {o.b[63], o.b} : {o.a[63], o.a} - {o.b[63], o.b};
      ref_cc = {r == 64'd0, r[63], o.fn < 2'd2 && (w[64] != w[63])};
   endfunction
   function automatic logic [63:0] rnd64();
      case ($urandom_range(3))
         0:       rnd64 = {$urandom, $urandom};
         1:       rnd64 = 64'($urandom_range(3));
         2:       rnd64 = 64'h8000_0000_0000_0000 | 64'($urandom_range(1));
         default: rnd64 = 64'h7FFF_FFFF_FFFF_FFFF - 64'($urandom_range(1));
      endcase
   endfunction
   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", n, act, exp);
      end
   endtask
   task automatic drive(input int r, input logic v, input op_t o);
      if (r == 0) begin
         bus.req0_valid = v; bus.req0_fn = o.fn; bus.req0_a = o.a; bus.req0_b = o.b; bus.req0_setcc = o.setcc;
      end else begin
         bus.req1_valid = v; bus.req1_fn = o.fn; bus.req1_a = o.a; bus.req1_b = o.b; bus.req1_setcc = o.setcc;
      end
   endtask
   function automatic logic rdy(input int r);
      rdy = r == 0 ? bus.req0_ready : bus.req1_ready;
   endfunction
   function automatic logic rv(input int r);
      rv = r == 0 ? bus.rsp0_valid : bus.rsp1_valid;
   endfunction
   function automatic logic [63:0] rd(input int r);
      rd = r == 0 ? bus.rsp0_data : bus.rsp1_data;
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      op_t z;
      z = '{2'd0, 64'd0, 64'd0, 1'b0};
      rst = 1'b1;
      bus.flush = 1'b0;
      drive(0, 1'b0, z);
      drive(1, 1'b0, z);
      repeat (2) tick();
      rst = 1'b0;
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      vec_t vecs[8];
      op_t  op0, op1, pend[2], ex;
      int   gs[6];
      int   g, ex_id, lastw;
      bit   pv[2], ex_v, exp_rv[2], exp_busy, fl;
      logic [63:0] exp_d[2];
      logic [2:0]  exp_c;
      vecs[0] = '{0, '{ALU_ADD, 64'd5, 64'd7, 1'b1}, 64'd12, 3'b000};
      vecs[1] = '{1, '{ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1}, 64'h8000_0000_0000_0000, 3'b011};
      vecs[2] = '{1, '{ALU_AND, 64'hF0, 64'h0F, 1'b1}, 64'd0, 3'b100};
      vecs[3] = '{0, '{ALU_SUB, 64'd3, 64'd3, 1'b1}, 64'd0, 3'b100};
      vecs[4] = '{0, '{ALU_XOR, 64'd1, 64'd2, 1'b0}, 64'd3, 3'b100};
      vecs[5] = '{1, '{ALU_SUB, 64'd0, 64'd1, 1'b1}, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010};
      vecs[6] = '{0, '{ALU_SUB, 64'h8000_0000_0000_0000, 64'd1, 1'b1}, 64'h7FFF_FFFF_FFFF_FFFF, 3'b001};
      vecs[7] = '{1, '{ALU_XOR, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1}, 64'd0, 3'b100};
      op0 = '{ALU_ADD, 64'd10, 64'd0, 1'b0};
      op1 = '{ALU_ADD, 64'd20, 64'd0, 1'b0};
      // reset with both requesters asking
      rst = 1'b1;
      bus.flush = 1'b0;
      drive(0, 1'b1, op0);
      drive(1, 1'b1, op1);
      tick();
      chk("rst_ready0", bus.req0_ready, 0);
      chk("rst_ready1", bus.req1_ready, 0);
      tick();
      chk("rst_ready0_b", bus.req0_ready, 0);
      chk("rst_ready1_b", bus.req1_ready, 0);
      chk("rst_rsp0", bus.rsp0_valid, 0);
      chk("rst_rsp1", bus.rsp1_valid, 0);
      chk("rst_cc", bus.cc, 3'b100);
      chk("rst_busy", bus.busy, 0);
      rst = 1'b0;
      drive(0, 1'b0, op0);
      drive(1, 1'b0, op1);
      tick();
      // directed single ops
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].id, 1'b1, vecs[i].op);
         #1;
         chk("tbl_ready", rdy(vecs[i].id), 1);
         chk("tbl_other_ready", rdy(1 - vecs[i].id), 0);
         tick();
         drive(vecs[i].id, 1'b0, vecs[i].op);
         chk("tbl_busy", bus.busy, 1);
         chk("tbl_early_rsp", rv(vecs[i].id), 0);
         tick();
         chk("tbl_rsp_valid", rv(vecs[i].id), 1);
         chk("tbl_other_rsp", rv(1 - vecs[i].id), 0);
         chk("tbl_data", rd(vecs[i].id), vecs[i].exp_d);
         chk("tbl_cc", bus.cc, vecs[i].exp_cc);
      end
      // contention for six cycles
      do_reset();
      for (int k = 0; k < 8; k++) begin
         drive(0, k < 6, op0);
         drive(1, k < 6, op1);
         #1;
         if (k < 6) begin
            gs[k] = RR ? k % 2 : 0;
            chk("cont_ready0", bus.req0_ready, gs[k] == 0);
            chk("cont_ready1", bus.req1_ready, gs[k] == 1);
         end
         if (k >= 2) begin
            chk("cont_rsp0", bus.rsp0_valid, gs[k-2] == 0);
            chk("cont_rsp1", bus.rsp1_valid, gs[k-2] == 1);
            chk("cont_data", rd(gs[k-2]), gs[k-2] == 0 ? 64'd10 : 64'd20);
         end else begin
            chk("cont_rsp0_early", bus.rsp0_valid, 0);
            chk("cont_rsp1_early", bus.rsp1_valid, 0);
         end
         tick();
      end
      // flush kills the op in the stage register
      drive(0, 1'b1, '{ALU_ADD, 64'd1, 64'd1, 1'b1});
      #1;
      chk("fl_ready_n", bus.req0_ready, 1);
      tick();
      drive(0, 1'b0, op0);
      drive(1, 1'b1, '{ALU_XOR, 64'd5, 64'd6, 1'b1});
      bus.flush = 1'b1;
      #1;
      chk("fl_ready0", bus.req0_ready, 0);
      chk("fl_ready1", bus.req1_ready, 0);
      chk("fl_busy_n1", bus.busy, 1);
      tick();
      bus.flush = 1'b0;
      drive(1, 1'b0, op1);
      chk("fl_busy_n2", bus.busy, 0);
      chk("fl_rsp0", bus.rsp0_valid, 0);
      chk("fl_rsp1", bus.rsp1_valid, 0);
      chk("fl_cc", bus.cc, 3'b100);
      tick();
      chk("fl_rsp0_n3", bus.rsp0_valid, 0);
      chk("fl_rsp1_n3", bus.rsp1_valid, 0);
      // reset (with flush) mid-op discards the op
      drive(1, 1'b1, '{ALU_ADD, 64'd5, 64'd5, 1'b1});
      tick();
      drive(1, 1'b0, op1);
      rst = 1'b1;
      bus.flush = 1'b1;
      tick();
      rst = 1'b0;
      bus.flush = 1'b0;
      chk("rmid_rsp1", bus.rsp1_valid, 0);
      chk("rmid_cc", bus.cc, 3'b100);
      chk("rmid_busy", bus.busy, 0);
      chk("rmid_data", bus.rsp1_data, 64'd0);
      tick();
      chk("rmid_rsp1_n3", bus.rsp1_valid, 0);
      // randomized traffic against the reference model
      do_reset();
      pv = '{0, 0};
      ex_v = 1'b0;
      ex_id = 0;
      exp_rv = '{0, 0};
      exp_d = '{64'd0, 64'd0};
      exp_c = CC_RESET;
      exp_busy = 1'b0;
      lastw = 1;
      for (int cyc = 0; cyc < 600; cyc++) begin
         tick();
         chk("rnd_rsp0_valid", bus.rsp0_valid, exp_rv[0]);
         chk("rnd_rsp1_valid", bus.rsp1_valid, exp_rv[1]);
         chk("rnd_rsp0_data", bus.rsp0_data, exp_d[0]);
         chk("rnd_rsp1_data", bus.rsp1_data, exp_d[1]);
         chk("rnd_cc", bus.cc, exp_c);
         chk("rnd_busy", bus.busy, exp_busy);
         for (int r = 0; r < 2; r++)
            if (!pv[r] && $urandom_range(9) < 6) begin
               pv[r] = 1'b1;
               pend[r] = '{2'($urandom_range(3)), rnd64(), rnd64(), 1'($urandom_range(1))};
            end
         fl = $urandom_range(9) == 0;
         drive(0, pv[0], pend[0]);
         drive(1, pv[1], pend[1]);
         bus.flush = fl;
         #1;
         if (fl) g = -1;
         else if (pv[0] && pv[1]) g = RR ? 1 - lastw : 0;
         else if (pv[0]) g = 0;
         else if (pv[1]) g = 1;
         else g = -1;
         chk("rnd_ready0", bus.req0_ready, g == 0);
         chk("rnd_ready1", bus.req1_ready, g == 1);
         exp_rv = '{0, 0};
         if (ex_v && !fl) begin
            exp_rv[ex_id] = 1'b1;
            exp_d[ex_id] = ref_res(ex);
            if (ex.setcc) exp_c = ref_cc(ex);
         end
         ex_v = g >= 0;
         if (ex_v) begin
            ex = pend[g];
            ex_id = g;
            pv[g] = 1'b0;
            lastw = g;
         end
         exp_busy = ex_v;
      end
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_issue_arb.md
# alu_issue_arb

Two-requester issue controller for the shared 64-bit ALU in the pipelined Y86 core. It arbitrates between two requesters, one op per cycle, with a valid/ready handshake, and registers each granted op before driving the ALU. It captures the ALU result into per-requester response registers and maintains the Y86 condition-code register {ZF,SF,OF}.

## Interface
- `DATA_W`, 64: operand/result width; fixed by the ALU.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 has an op.
- `req0_ready` out 1: grant; the handshake is `valid & ready` in the same cycle.
- `req0_fn` in 2: 00 add, 01 sub (a−b), 10 and, 11 xor.
- `req0_a`, `req0_b` in DATA_W: operands.
- `req0_setcc` in 1: op updates CC.
- `req1_*`: same set of ports as requester 0.
- `rsp0_valid` out 1: one-cycle result pulse; no backpressure.
- `rsp0_data` out DATA_W: result, held until the next rsp0 pulse.
- `rsp1_valid`, `rsp1_data`: same as requester 0.
- `alu_control` out 2: drives the ALU's 2-bit function select.
- `alu_a`, `alu_b` out DATA_W: ALU operand inputs.
- `alu_out` in DATA_W: ALU result.
- `alu_of` in 1: ALU signed-overflow flag for add/sub.
- `cc` out 3: {ZF,SF,OF}.
- `flush` in 1: kill the op in flight; no issue this cycle.
- `busy` out 1: stage register holds a valid op.

## Operation
- **Issue (cycle N):** when `flush`=0, at most one `reqX_ready` is high, given to a valid requester per the arbitration policy. `ready` is never high for a requester with `valid`=0. On handshake, fn, a, b, setcc and requester id load into the stage register.
- **Execute (N+1):** the stage register drives `alu_control`, `alu_a`, `alu_b` directly (no combinational path from `req*`). At the end of N+1, `alu_out` loads into the owning `rspX_data` and `rspX_valid` pulses during N+2.
- **CC update:** at the end of N+1, when setcc=1:
  - ZF = (`alu_out`==0)
  - SF = `alu_out[63]`
  - OF = `alu_of` for fn 00/01, forced 0 for fn 10/11.
  - With setcc=0, CC holds.
- **Flush:** `flush`=1 during N+1 clears the stage register at the end of that cycle. No rsp pulse, no CC update. `ready` is forced 0 while `flush`=1.
- **Idle stage:** the ALU inputs hold their last values, and `busy`=0.
- **Reset** (synchronous, takes priority over everything): stage invalid, all rsp_valid 0, rsp_data 0, `alu_*` outputs 0, cc=3'b100, arbitration pointer favours req0. `ready` is 0 while `rst`=1.
- **Reset mid-op:** an in-flight op is discarded with no response pulse.

## Timing
- Latency: handshake at N → `rspX_valid` at N+2. CC visible from N+2.
- Throughput: one op per cycle, sustained. Back-to-back ops from the same requester pulse on consecutive cycles.
- Simultaneous valid: exactly one grant per cycle; the loser's `ready`=0 and it must hold its inputs.
- `flush` and `rst` asserted together: `rst` wins, with identical end state.

## Configuration
- **`ALU_ARB_RR_EN` defined:** round-robin arbitration. Under contention the grant alternates; the pointer updates only on a handshake and points away from the last winner.
- **Undefined:** fixed priority. req0 always wins, and req1 is granted only when `req0_valid`=0.

## Structure
- **Shared package `alu_arb_pkg`:**
  - fn encodings `ALU_ADD`/`ALU_SUB`/`ALU_AND`/`ALU_XOR`
  - CC bit indices `CC_ZF`=2, `CC_SF`=1, `CC_OF`=0
  - `CC_RESET`=3'b100
  - the stage-register struct (fn, a, b, setcc, id, valid)
- **Sub-module `arb_rr2`:** 2-way arbiter, the sole place where `ALU_ARB_RR_EN` is tested. The top level holds the stage, response and CC registers.

## Test plan
- **Reset:** hold `rst` 2 cycles with both valid high → ready 0/0, rsp_valid 0/0, cc=100, busy=0.
- **Add with CC:** req0 add 5+7, setcc=1 at N → `rsp0_valid` at N+2, data 12, cc=000. `rsp1_valid` stays 0.
- **Overflow and CC masking:**
  - req1 add 0x7FFF_FFFF_FFFF_FFFF+1, setcc=1 → `rsp1_data`=0x8000_0000_0000_0000, cc=011.
  - Then and 0xF0 & 0x0F, setcc=1 → data 0, cc=100 (OF cleared).
- **Sub with ZF, then CC hold:** req0 sub 3−3, setcc=1 → data 0, cc=100. Then xor 1^2 with setcc=0 → data 3, cc stays 100.
- **Contention:** both valid for 6 cycles.
  - With `ALU_ARB_RR_EN`: grants 0,1,0,1,0,1 and rsp pulses alternate.
  - Without: 6 grants to req0, `req1_ready` 0 throughout.
- **Flush:** handshake at N, `flush`=1 at N+1 → no rsp pulse at N+2, cc unchanged, no grant at N+1, busy=0 at N+2.
